// File: rtl/tile_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// tile_scheduler_pkg: FSM state encoding and default PE array edge. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tile_scheduler_pkg;

  localparam int DEF_PE_DIM = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/tile_scheduler_if.sv
// ---------------------------------------------------------------------------
// tile_scheduler_if: pass handshake and per-pass configuration bus. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface tile_scheduler_if #(
  parameter int ADDR_W = 32
);

  logic              pass_start_o;
  logic              pass_done_i;
  logic [31:0]       tile_n_o;
  logic [7:0]        IC_real_o;
  logic [7:0]        OC_real_o;
  logic [31:0]       On_real_o;
  logic [ADDR_W-1:0] weight_GLB_base_addr_o;
  logic [ADDR_W-1:0] ifmap_GLB_base_addr_o;
  logic [ADDR_W-1:0] ipsum_GLB_base_addr_o;
  logic [ADDR_W-1:0] bias_GLB_base_addr_o;
  logic [ADDR_W-1:0] opsum_GLB_base_addr_o;
  logic              is_bias_o;

  modport master (
    output pass_start_o, tile_n_o, IC_real_o, OC_real_o, On_real_o,
           weight_GLB_base_addr_o, ifmap_GLB_base_addr_o, ipsum_GLB_base_addr_o,
           bias_GLB_base_addr_o, opsum_GLB_base_addr_o, is_bias_o,
    input  pass_done_i
  );

  modport slave (
    input  pass_start_o, tile_n_o, IC_real_o, OC_real_o, On_real_o,
           weight_GLB_base_addr_o, ifmap_GLB_base_addr_o, ipsum_GLB_base_addr_o,
           bias_GLB_base_addr_o, opsum_GLB_base_addr_o, is_bias_o,
    output pass_done_i
  );

endinterface

`default_nettype wire

// File: rtl/tile_scheduler_dim_counter.sv
// ---------------------------------------------------------------------------
// tile_dim_counter: remaining-count tile walker with min clamp and index. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tile_dim_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         adv_i,
  input  logic [W-1:0] total_i,
  input  logic [W-1:0] size_i,
  output logic [W-1:0] real_o,
  output logic [W-1:0] idx_o,
  output logic         last_o
);

  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] idx_q, idx_d;

  // adv_i is only raised when last_o is low, so the subtract cannot underflow
  always_comb begin
    rem_d = rem_q;
    idx_d = idx_q;
    if (load_i) begin
      rem_d = total_i;
      idx_d = '0;
    end else if (adv_i) begin
      rem_d = rem_q - size_i;
      idx_d = idx_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      idx_q <= '0;
    end else begin
      rem_q <= rem_d;
      idx_q <= idx_d;
    end
  end

  assign last_o = (rem_q <= size_i);
  assign real_o = last_o ? rem_q : size_i;
  assign idx_o  = idx_q;

endmodule

`default_nettype wire

// File: rtl/tile_scheduler.sv
// ---------------------------------------------------------------------------
// tile_scheduler: walks OC/row/IC tiles and issues one token_engine pass each. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tile_scheduler
  import tile_scheduler_pkg::*;
#(
  parameter int PE_DIM = DEF_PE_DIM,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              layer_start_i,
  output logic              layer_done_o,
  output logic              busy_o,
  input  logic [CNT_W-1:0]  IC_total_i,
  input  logic [CNT_W-1:0]  OC_total_i,
  input  logic [CNT_W-1:0]  On_total_i,
  input  logic [CNT_W-1:0]  rows_per_tile_i,
  input  logic [ADDR_W-1:0] weight_base_i,
  input  logic [ADDR_W-1:0] ifmap_base_i,
  input  logic [ADDR_W-1:0] opsum_base_i,
  input  logic [ADDR_W-1:0] bias_base_i,
  input  logic [ADDR_W-1:0] weight_ic_stride_i,
  input  logic [ADDR_W-1:0] weight_oc_stride_i,
  input  logic [ADDR_W-1:0] ifmap_ic_stride_i,
  input  logic [ADDR_W-1:0] ifmap_n_stride_i,
  input  logic [ADDR_W-1:0] opsum_oc_stride_i,
  input  logic [ADDR_W-1:0] opsum_n_stride_i,
  tile_scheduler_if.master  pass_if
);

  localparam logic [CNT_W-1:0]  PE_CNT    = CNT_W'(PE_DIM);
  localparam logic [ADDR_W-1:0] BIAS_STEP = ADDR_W'(PE_DIM * 4);

  state_e state_q, state_d;

  logic [CNT_W-1:0]  ic_tot_q, oc_tot_q, on_tot_q, rows_q;
  logic [ADDR_W-1:0] w_base_q, f_base_q, o_base_q, b_base_q;
  logic [ADDR_W-1:0] w_ic_str_q, w_oc_str_q, f_ic_str_q, f_n_str_q, o_oc_str_q, o_n_str_q;

  // *_oc / *_n registers hold the rewind point of the enclosing loop level
  logic [ADDR_W-1:0] weight_q, weight_d, weight_oc_q, weight_oc_d;
  logic [ADDR_W-1:0] ifmap_q, ifmap_d, ifmap_n_q, ifmap_n_d;
  logic [ADDR_W-1:0] opsum_q, opsum_d, opsum_oc_q, opsum_oc_d;
  logic [ADDR_W-1:0] bias_q, bias_d;

  logic [CNT_W-1:0] ic_real, oc_real, n_real;
  logic [CNT_W-1:0] ic_idx, oc_idx, n_idx;
  logic             ic_last, oc_last, n_last;
  logic             ic_load, ic_adv, n_load, n_adv, oc_load, oc_adv;
  logic             in_setup, in_next;
  logic             pass_start, layer_done, busy;
  logic             unused_oc_idx;

  assign in_setup = (state_q == ST_SETUP);
  assign in_next  = (state_q == ST_NEXT);

  assign ic_load = in_setup || (in_next && ic_last);
  assign ic_adv  = in_next && !ic_last;
  assign n_load  = in_setup || (in_next && ic_last && n_last);
  assign n_adv   = in_next && ic_last && !n_last;
  assign oc_load = in_setup;
  assign oc_adv  = in_next && ic_last && n_last && !oc_last;

  tile_dim_counter #(.W(CNT_W)) u_ic_cnt (
    .clk(clk), .rst(rst), .load_i(ic_load), .adv_i(ic_adv),
    .total_i(ic_tot_q), .size_i(PE_CNT),
    .real_o(ic_real), .idx_o(ic_idx), .last_o(ic_last)
  );

  tile_dim_counter #(.W(CNT_W)) u_n_cnt (
    .clk(clk), .rst(rst), .load_i(n_load), .adv_i(n_adv),
    .total_i(on_tot_q), .size_i(rows_q),
    .real_o(n_real), .idx_o(n_idx), .last_o(n_last)
  );

  tile_dim_counter #(.W(CNT_W)) u_oc_cnt (
    .clk(clk), .rst(rst), .load_i(oc_load), .adv_i(oc_adv),
    .total_i(oc_tot_q), .size_i(PE_CNT),
    .real_o(oc_real), .idx_o(oc_idx), .last_o(oc_last)
  );

  assign unused_oc_idx = ^oc_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (layer_start_i) state_d = ST_SETUP;
      ST_SETUP: begin
        if (ic_tot_q == '0 || oc_tot_q == '0 || on_tot_q == '0) state_d = ST_DONE;
        else                                                    state_d = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (pass_if.pass_done_i) state_d = ST_NEXT;
      ST_NEXT:  state_d = (ic_last && n_last && oc_last) ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pass_start = (state_q == ST_ISSUE);
    layer_done = (state_q == ST_DONE);
    busy       = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ic_tot_q   <= '0;
      oc_tot_q   <= '0;
      on_tot_q   <= '0;
      rows_q     <= '0;
      w_base_q   <= '0;
      f_base_q   <= '0;
      o_base_q   <= '0;
      b_base_q   <= '0;
      w_ic_str_q <= '0;
      w_oc_str_q <= '0;
      f_ic_str_q <= '0;
      f_n_str_q  <= '0;
      o_oc_str_q <= '0;
      o_n_str_q  <= '0;
    end else if (state_q == ST_IDLE && layer_start_i) begin
      ic_tot_q   <= IC_total_i;
      oc_tot_q   <= OC_total_i;
      on_tot_q   <= On_total_i;
      rows_q     <= rows_per_tile_i;
      w_base_q   <= weight_base_i;
      f_base_q   <= ifmap_base_i;
      o_base_q   <= opsum_base_i;
      b_base_q   <= bias_base_i;
      w_ic_str_q <= weight_ic_stride_i;
      w_oc_str_q <= weight_oc_stride_i;
      f_ic_str_q <= ifmap_ic_stride_i;
      f_n_str_q  <= ifmap_n_stride_i;
      o_oc_str_q <= opsum_oc_stride_i;
      o_n_str_q  <= opsum_n_stride_i;
    end
  end

  always_comb begin
    weight_d    = weight_q;
    weight_oc_d = weight_oc_q;
    ifmap_d     = ifmap_q;
    ifmap_n_d   = ifmap_n_q;
    opsum_d     = opsum_q;
    opsum_oc_d  = opsum_oc_q;
    bias_d      = bias_q;
    if (in_setup) begin
      weight_d    = w_base_q;
      weight_oc_d = w_base_q;
      ifmap_d     = f_base_q;
      ifmap_n_d   = f_base_q;
      opsum_d     = o_base_q;
      opsum_oc_d  = o_base_q;
      bias_d      = b_base_q;
    end else if (in_next) begin
      if (!ic_last) begin
        weight_d = weight_q + w_ic_str_q;
        ifmap_d  = ifmap_q + f_ic_str_q;
      end else if (!n_last) begin
        weight_d  = weight_oc_q;
        ifmap_n_d = ifmap_n_q + f_n_str_q;
        ifmap_d   = ifmap_n_q + f_n_str_q;
        opsum_d   = opsum_q + o_n_str_q;
      end else if (!oc_last) begin
        weight_oc_d = weight_oc_q + w_oc_str_q;
        weight_d    = weight_oc_q + w_oc_str_q;
        ifmap_n_d   = f_base_q;
        ifmap_d     = f_base_q;
        opsum_oc_d  = opsum_oc_q + o_oc_str_q;
        opsum_d     = opsum_oc_q + o_oc_str_q;
        bias_d      = bias_q + BIAS_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      weight_q    <= '0;
      weight_oc_q <= '0;
      ifmap_q     <= '0;
      ifmap_n_q   <= '0;
      opsum_q     <= '0;
      opsum_oc_q  <= '0;
      bias_q      <= '0;
    end else begin
      weight_q    <= weight_d;
      weight_oc_q <= weight_oc_d;
      ifmap_q     <= ifmap_d;
      ifmap_n_q   <= ifmap_n_d;
      opsum_q     <= opsum_d;
      opsum_oc_q  <= opsum_oc_d;
      bias_q      <= bias_d;
    end
  end

  assign layer_done_o = layer_done;
  assign busy_o       = busy;

  assign pass_if.pass_start_o           = pass_start;
  assign pass_if.tile_n_o               = 32'(n_idx);
  assign pass_if.IC_real_o              = 8'(ic_real);
  assign pass_if.OC_real_o              = 8'(oc_real);
  assign pass_if.On_real_o              = 32'(n_real);
  assign pass_if.weight_GLB_base_addr_o = weight_q;
  assign pass_if.ifmap_GLB_base_addr_o  = ifmap_q;
  assign pass_if.ipsum_GLB_base_addr_o  = opsum_q;
  assign pass_if.opsum_GLB_base_addr_o  = opsum_q;
  assign pass_if.bias_GLB_base_addr_o   = bias_q;
  // a nonzero IC clamp distinguishes a live first IC tile from the cleared idle state
  assign pass_if.is_bias_o              = (ic_idx == '0) && (ic_real != '0);

endmodule

`default_nettype wire
